// File: rtl/imagem_ram_arbiter_if.sv
// Signal bundle of the image RAM arbiter: CPU Avalon-MM slave, scan control,
// pixel stream and the single-port RAM master port.
interface imagem_ram_arbiter_if;
    logic [15:0] cpu_address;
    logic        cpu_chipselect;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_writedata;
    logic [7:0]  cpu_readdata;
    logic        cpu_waitrequest;
    logic        scan_start;
    logic [15:0] scan_base;
    logic [15:0] scan_length;
    logic        scan_busy;
    logic        scan_done;
    logic [7:0]  px_data;
    logic        px_valid;
    logic        px_ready;
    logic [15:0] ram_address;
    logic        ram_chipselect;
    logic        ram_write;
    logic        ram_clken;
    logic [7:0]  ram_writedata;
    logic [7:0]  ram_readdata;

    modport slave (
        input  cpu_address, cpu_chipselect, cpu_read, cpu_write,
        input  cpu_writedata, scan_start, scan_base, scan_length,
        input  px_ready, ram_readdata,
        output cpu_readdata, cpu_waitrequest, scan_busy, scan_done,
        output px_data, px_valid, ram_address, ram_chipselect,
        output ram_write, ram_clken, ram_writedata
    );

    modport master (
        output cpu_address, cpu_chipselect, cpu_read, cpu_write,
        output cpu_writedata, scan_start, scan_base, scan_length,
        output px_ready, ram_readdata,
        input  cpu_readdata, cpu_waitrequest, scan_busy, scan_done,
        input  px_data, px_valid, ram_address, ram_chipselect,
        input  ram_write, ram_clken, ram_writedata
    );
endinterface

// File: rtl/imagem_ram_arbiter.sv
// Round-robin arbiter sharing one image RAM between a Nios CPU slave port
// and a sequential pixel scanner feeding a small valid/ready FIFO.
module imagem_ram_arbiter #(
    parameter int DEPTH      = 58368,
    parameter int FIFO_DEPTH = 2
) (
    input logic clk,
    input logic reset_n,
    imagem_ram_arbiter_if.slave bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   remaining_q, remaining_d;
    logic          inflight_q, inflight_d;
    logic          last_cpu_q, last_cpu_d;
    logic          rphase_q, rphase_d;
    logic [7:0]    rdata_q, rdata_d;
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [7:0]    fifo_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic cpu_raw, cpu_in, cpu_req, cpu_oor, scan_req;
    logic gnt_cpu, gnt_scan, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign cpu_raw  = bus.cpu_chipselect & (bus.cpu_read | bus.cpu_write);
    assign cpu_in   = 32'(bus.cpu_address) < 32'(DEPTH);
    // the data phase of a read is its own ack cycle, not a new request
    assign cpu_req  = cpu_raw & ~rphase_q & cpu_in;
    assign cpu_oor  = cpu_raw & ~rphase_q & ~cpu_in;
    assign scan_req = (state_q == S_RUN) && (remaining_q != 16'd0) &&
                      ((32'(cnt_q) + 32'(inflight_q)) < 32'(FIFO_DEPTH));
    assign gnt_cpu  = cpu_req & (~scan_req | ~last_cpu_q);
    assign gnt_scan = scan_req & ~gnt_cpu;
    assign push     = inflight_q;
    assign pop      = (cnt_q != '0) & bus.px_ready;

    assign bus.ram_clken       = 1'b1;
    assign bus.ram_chipselect  = gnt_cpu | gnt_scan;
    assign bus.ram_write       = gnt_cpu & bus.cpu_write;
    assign bus.ram_address     = gnt_scan ? addr_q : bus.cpu_address;
    assign bus.ram_writedata   = bus.cpu_writedata;
    assign bus.cpu_waitrequest = ~((gnt_cpu & bus.cpu_write) | rphase_q | cpu_oor);
    assign bus.cpu_readdata    = rdata_d;
    assign bus.scan_busy       = (state_q != S_IDLE);
    assign bus.scan_done       = (state_q == S_DONE);
    assign bus.px_valid        = (cnt_q != '0);
    assign bus.px_data         = fifo_q[rd_ptr_q];

    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        inflight_d  = gnt_scan;
        last_cpu_d  = last_cpu_q;
        rphase_d    = gnt_cpu & ~bus.cpu_write;
        rdata_d     = rdata_q;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (gnt_cpu) begin
            last_cpu_d = 1'b1;
        end else if (gnt_scan) begin
            last_cpu_d = 1'b0;
        end
        if (rphase_q) begin
            rdata_d = bus.ram_readdata;
        end else if (cpu_oor & ~bus.cpu_write) begin
            rdata_d = 8'h00;
        end
        if (gnt_scan) begin
            addr_d      = (addr_q == 16'(DEPTH - 1)) ? 16'd0 : addr_q + 16'd1;
            remaining_d = remaining_q - 16'd1;
        end
        if (state_q == S_IDLE && bus.scan_start) begin
            addr_d      = 16'(32'(bus.scan_base) % 32'(DEPTH));
            remaining_d = bus.scan_length;
        end
        if (push) begin
            fifo_d[wr_ptr_q] = bus.ram_readdata;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.scan_start) state_d = S_RUN;
            S_RUN:   if (remaining_q == 16'd0 && !inflight_q) state_d = S_DRAIN;
            S_DRAIN: if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            last_cpu_q  <= 1'b0;
            rphase_q    <= 1'b0;
            rdata_q     <= '0;
            fifo_q      <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            last_cpu_q  <= last_cpu_d;
            rphase_q    <= rphase_d;
            rdata_q     <= rdata_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_imagem_ram_arbiter.sv
// Randomized scoreboard bench for imagem_ram_arbiter with a behavioural
// RAM image model and queue-based pixel/CPU-read expectations.
module tb_imagem_ram_arbiter;
    localparam int DEPTH = 58368;
    localparam int FIFO_DEPTH = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    imagem_ram_arbiter_if bus();

    imagem_ram_arbiter #(.DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    byte unsigned mem [DEPTH];
    byte unsigned ref_mem [DEPTH];
    int checks = 0;
    int failures = 0;
    int px_exp_q [$];
    int cpu_exp_q [$];
    int ready_mode = 0;
    int gnt_cnt = 0;
    int pop_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // synchronous single-port RAM: read data appears the cycle after access
    always @(posedge clk) begin
        if (bus.ram_chipselect && bus.ram_clken) begin
            if (bus.ram_write) mem[bus.ram_address] <= bus.ram_writedata;
            bus.ram_readdata <= mem[bus.ram_address];
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: bus.px_ready = 1'b1;
            1: bus.px_ready = 1'($urandom % 2);
            default: bus.px_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.ram_chipselect) gnt_cnt++;
            if (bus.px_valid && bus.px_ready) begin
                pop_cnt++;
                if (px_exp_q.size() == 0) chk("px_extra", 1, 0);
                else chk("px_data", int'(bus.px_data), px_exp_q.pop_front());
            end
            if (bus.cpu_chipselect && bus.cpu_read && !bus.cpu_write &&
                !bus.cpu_waitrequest) begin
                if (cpu_exp_q.size() == 0) chk("rd_extra", 1, 0);
                else chk("cpu_readdata", int'(bus.cpu_readdata), cpu_exp_q.pop_front());
            end
        end
    end

    task automatic cpu_wr(input int addr, input int data);
        int lat = 0;
        bus.cpu_chipselect = 1'b1;
        bus.cpu_write = 1'b1;
        bus.cpu_read = 1'b0;
        bus.cpu_address = 16'(addr);
        bus.cpu_writedata = 8'(data);
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (!bus.cpu_waitrequest) begin
                lat = k;
                break;
            end
        end
        if (addr >= DEPTH) chk("oor_wr_ram_write", int'(bus.ram_write), 0);
        chk("wr_latency", lat, 1);
        @(posedge clk); #1;
        bus.cpu_chipselect = 1'b0;
        bus.cpu_write = 1'b0;
        if (addr < DEPTH) ref_mem[addr] = 8'(data);
    endtask

    task automatic cpu_rd(input int addr, input int lo, input int hi);
        int lat = 0;
        cpu_exp_q.push_back(addr < DEPTH ? int'(ref_mem[addr]) : 0);
        bus.cpu_chipselect = 1'b1;
        bus.cpu_read = 1'b1;
        bus.cpu_write = 1'b0;
        bus.cpu_address = 16'(addr);
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (!bus.cpu_waitrequest) begin
                lat = k;
                break;
            end
        end
        if (addr >= DEPTH) chk("oor_rd_ram_cs", int'(bus.ram_chipselect), 0);
        chk_rng("rd_latency", lat, lo, hi);
        @(posedge clk); #1;
        bus.cpu_chipselect = 1'b0;
        bus.cpu_read = 1'b0;
    endtask

    task automatic do_scan(input int base, input int len, input bit spurious, input bit solo);
        int lat = 0;
        int b = base % DEPTH;
        for (int i = 0; i < len; i++) px_exp_q.push_back(int'(ref_mem[(b + i) % DEPTH]));
        gnt_cnt = 0;
        pop_cnt = 0;
        bus.scan_base = 16'(base);
        bus.scan_length = 16'(len);
        bus.scan_start = 1'b1;
        @(posedge clk); #1;
        bus.scan_start = 1'b0;
        for (int k = 1; k <= 4000; k++) begin
            @(negedge clk);
            if (bus.scan_done) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
            bus.scan_start = spurious && (k == 2);
            if (spurious && k == 2) begin
                bus.scan_base = 16'(base + 8'h80);
                bus.scan_length = 16'd5;
            end
        end
        chk("scan_done_seen", int'(lat != 0), 1);
        if (len == 0) chk("zero_len_done_lat", lat, 3);
        if (solo) chk("scan_ram_reads", gnt_cnt, len);
        chk("px_all_delivered", px_exp_q.size(), 0);
        @(negedge clk);
        chk("busy_after_done", int'(bus.scan_busy), 0);
        chk("done_one_cycle", int'(bus.scan_done), 0);
        @(posedge clk); #1;
        bus.scan_start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cpu_address = '0;
        bus.cpu_chipselect = 1'b0;
        bus.cpu_read = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_writedata = '0;
        bus.scan_start = 1'b0;
        bus.scan_base = '0;
        bus.scan_length = '0;
        bus.px_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_scan_busy", int'(bus.scan_busy), 0);
        chk("rst_scan_done", int'(bus.scan_done), 0);
        chk("rst_px_valid", int'(bus.px_valid), 0);
        chk("rst_ram_cs", int'(bus.ram_chipselect), 0);
        chk("rst_cpu_readdata", int'(bus.cpu_readdata), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        cpu_wr(16'h0010, 8'h5A);
        cpu_rd(16'h0010, 2, 2);

        for (int i = 0; i < 8; i++) cpu_wr(i, i);
        do_scan(0, 8, 0, 1);
        do_scan(0, 0, 0, 1);

        cpu_wr(16'hE3FE, 8'hA1);
        cpu_wr(16'hE3FF, 8'hA2);
        cpu_wr(16'h0000, 8'hA3);
        cpu_wr(16'h0001, 8'hA4);
        do_scan(16'hE3FE, 4, 0, 1);
        do_scan(16'hE402, 3, 0, 1);

        for (int i = 32; i < 48; i++) cpu_wr(i, $urandom % 256);
        fork
            do_scan(32, 16, 0, 0);
            begin
                for (int i = 0; i < 12; i++) cpu_rd(32 + $urandom % 16, 2, 3);
            end
        join

        for (int i = 0; i < 24; i++) cpu_wr(16'h0100 + i, i ^ 8'h3C);
        fork
            do_scan(16'h0100, 24, 0, 1);
            begin
                repeat (6) @(posedge clk);
                #1;
                ready_mode = 2;
                repeat (20) begin
                    @(negedge clk);
                    chk_rng("outstanding", gnt_cnt - pop_cnt, 0, FIFO_DEPTH);
                end
                chk("stall_full", gnt_cnt - pop_cnt, FIFO_DEPTH);
                ready_mode = 0;
            end
        join

        cpu_rd(16'hE400, 1, 1);
        cpu_wr(16'hFFFF, 8'h77);
        for (int i = 0; i < 6; i++) cpu_wr(16'h0040 + i, 8'hC0 + i);
        do_scan(16'h0040, 6, 1, 0);

        for (int it = 0; it < 40; it++) begin
            int op = $urandom % 10;
            int a = ($urandom % 8 == 0) ? int'($urandom_range(16'hE400, 16'hFFFF))
                                        : int'($urandom % 256);
            if (op < 4) begin
                cpu_wr(a, $urandom % 256);
            end else if (op < 7) begin
                if (a < DEPTH) cpu_rd(a, 2, 2);
                else cpu_rd(a, 1, 1);
            end else begin
                int sb = ($urandom % 4 == 0) ? 16'hE3F8 + int'($urandom % 16)
                                             : int'($urandom % 256);
                ready_mode = $urandom % 2;
                do_scan(sb, $urandom % 10, 0, 1);
                ready_mode = 0;
            end
        end

        cpu_wr(16'h0010, 8'h5A);
        cpu_rd(16'h0010, 2, 2);
        repeat (3) @(negedge clk);
        chk("readdata_hold", int'(bus.cpu_readdata), 8'h5A);
        @(posedge clk); #1;

        ready_mode = 1;
        for (int i = 0; i < 40; i++) px_exp_q.push_back(int'(ref_mem[16'h30 + i]));
        bus.scan_base = 16'h0030;
        bus.scan_length = 16'd40;
        bus.scan_start = 1'b1;
        @(posedge clk); #1;
        bus.scan_start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_scan_busy", int'(bus.scan_busy), 0);
        chk("mid_rst_scan_done", int'(bus.scan_done), 0);
        chk("mid_rst_px_valid", int'(bus.px_valid), 0);
        chk("mid_rst_ram_cs", int'(bus.ram_chipselect), 0);
        chk("mid_rst_ram_write", int'(bus.ram_write), 0);
        chk("mid_rst_readdata", int'(bus.cpu_readdata), 0);
        px_exp_q.delete();
        cpu_exp_q.delete();
        ready_mode = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_scan(0, 8, 0, 1);
        cpu_rd(16'h0005, 2, 2);

        chk("cpu_queue_empty", cpu_exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
